puzzle_dealer: RTL and testbench

PUZZLE_DEALER -- requirements
Module: puzzle_dealer

---
 rtl/puzzle_dealer.sv | 100 ++++++++++
 tb/tb_puzzle_dealer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/puzzle_dealer.sv
// Puzzle dealer: hands out ROUNDS distinct puzzle-set indices per game, seeding
// the search from a free-running entropy counter and tallying solved rounds.
module puzzle_dealer #(
    parameter int ROUNDS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       advance,
    input  logic       solved,
    output logic [3:0] index,
    output logic       index_valid,
    output logic [4:0] round,
    output logic [4:0] score,
    output logic       game_over
);

    typedef enum logic [1:0] {IDLE, SEEK, PRESENT, DONE} state_t;

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

    state_t      state_q, state_d;
    logic [3:0]  entropy_q;
    logic [15:0] used_q, used_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [3:0]  index_q, index_d;
    logic [4:0]  round_q, round_d;
    logic [4:0]  score_q, score_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            entropy_q <= 4'd0;
            used_q    <= 16'd0;
            ptr_q     <= 4'd0;
            index_q   <= 4'd0;
            round_q   <= 5'd0;
            score_q   <= 5'd0;
        end else begin
            state_q   <= state_d;
            entropy_q <= entropy_q + 4'd1;
            used_q    <= used_d;
            ptr_q     <= ptr_d;
            index_q   <= index_d;
            round_q   <= round_d;
            score_q   <= score_d;
        end
    end

    always_comb begin
        state_d = state_q;
        used_d  = used_q;
        ptr_d   = ptr_q;
        index_d = index_q;
        round_d = round_q;
        score_d = score_q;
        // start from any state aborts the game and masks a simultaneous advance
        if (start) begin
            used_d  = 16'd0;
            round_d = 5'd1;
            score_d = 5'd0;
            ptr_d   = entropy_q;
            state_d = SEEK;
        end else begin
            case (state_q)
                SEEK: begin
                    if (used_q[ptr_q]) begin
                        ptr_d = ptr_q + 4'd1;
                    end else begin
                        index_d        = ptr_q;
                        used_d[ptr_q]  = 1'b1;
                        state_d        = PRESENT;
                    end
                end
                PRESENT: begin
                    if (advance) begin
                        score_d = score_q + 5'(solved);
                        if (round_q == LAST_ROUND) begin
                            state_d = DONE;
                        end else begin
                            round_d = round_q + 5'd1;
                            // odd stride keeps successive picks spread over the set
                            ptr_d   = ptr_q + (entropy_q | 4'd1);
                            state_d = SEEK;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign index       = index_q;
    assign index_valid = (state_q == PRESENT);
    assign round       = round_q;
    assign score       = score_q;
    assign game_over   = (state_q == DONE);

endmodule

// File: tb/tb_puzzle_dealer.sv
// Bench for puzzle_dealer: a cycle table on a 3-round instance, then reset and
// full-game scenarios on a 16-round instance, checked through expectation queues.
module tb_puzzle_dealer;

    logic clk = 1'b0;
    logic rst, start, advance, solved;
    logic [3:0] idx3, idx16;
    logic       v3, v16, g3, g16;
    logic [4:0] r3, r16, s3, s16;

    typedef struct packed {
        logic [3:0] idx;
        logic       v;
        logic [4:0] rnd;
        logic [4:0] scr;
        logic       go;
    } out_t;

    typedef struct packed {
        logic st;
        logic adv;
        logic sol;
        out_t exp;
    } vec_t;

    vec_t tbl [22];
    out_t exp_q [$];
    logic [9:0] exp16_q [$];
    int n_pass = 0;
    int n_total = 0;

    puzzle_dealer #(.ROUNDS(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .advance(advance), .solved(solved),
        .index(idx3), .index_valid(v3), .round(r3), .score(s3), .game_over(g3)
    );

    puzzle_dealer #(.ROUNDS(16)) dut16 (
        .clk(clk), .rst(rst), .start(start), .advance(advance), .solved(solved),
        .index(idx16), .index_valid(v16), .round(r16), .score(s16), .game_over(g16)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200us");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic st, input logic adv, input logic sol,
                                input logic [3:0] i, input logic v, input logic [4:0] r,
                                input logic [4:0] s, input logic go);
        vec_t t;
        t.st = st; t.adv = adv; t.sol = sol;
        t.exp.idx = i; t.exp.v = v; t.exp.rnd = r; t.exp.scr = s; t.exp.go = go;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s: got %0h", name, got);
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_valid16(output int cycles);
        cycles = 0;
        while (!v16 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic advance16(input logic sol);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        advance = 1'b1;
        solved  = sol;
        @(negedge clk);
        advance = 1'b0;
        solved  = 1'b0;
    endtask

    task automatic reset_and_start16();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        out_t got;
        out_t e;
        logic [15:0] seen;
        logic sol;
        int cyc;
        int exp_score;

        // inputs per edge after reset release, outputs expected after that edge
        tbl[0]  = mk(0, 0, 0,  0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 1,  0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0,  0, 0, 1, 0, 0);
        tbl[3]  = mk(0, 0, 0,  2, 1, 1, 0, 0);
        tbl[4]  = mk(0, 1, 1,  2, 0, 2, 1, 0);
        tbl[5]  = mk(0, 0, 0,  7, 1, 2, 1, 0);
        tbl[6]  = mk(0, 0, 1,  7, 1, 2, 1, 0);
        tbl[7]  = mk(0, 1, 0,  7, 0, 3, 1, 0);
        tbl[8]  = mk(0, 0, 0, 14, 1, 3, 1, 0);
        tbl[9]  = mk(0, 1, 1, 14, 0, 3, 2, 1);
        tbl[10] = mk(0, 1, 1, 14, 0, 3, 2, 1);
        tbl[11] = mk(0, 0, 0, 14, 0, 3, 2, 1);
        tbl[12] = mk(0, 0, 0, 14, 0, 3, 2, 1);
        tbl[13] = mk(0, 0, 0, 14, 0, 3, 2, 1);
        tbl[14] = mk(1, 0, 0, 14, 0, 1, 0, 0);
        tbl[15] = mk(0, 0, 0, 14, 1, 1, 0, 0);
        tbl[16] = mk(0, 1, 1, 14, 0, 2, 1, 0);
        tbl[17] = mk(0, 0, 0, 15, 1, 2, 1, 0);
        tbl[18] = mk(1, 1, 1, 15, 0, 1, 0, 0);
        tbl[19] = mk(0, 0, 0,  2, 1, 1, 0, 0);
        tbl[20] = mk(0, 1, 0,  2, 0, 2, 0, 0);
        tbl[21] = mk(0, 0, 0,  7, 1, 2, 0, 0);

        rst = 1'b1; start = 1'b0; advance = 1'b0; solved = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_dut3", 32'({idx3, v3, r3, s3, g3}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            start   = tbl[i].st;
            advance = tbl[i].adv;
            solved  = tbl[i].sol;
            exp_q.push_back(tbl[i].exp);
            @(negedge clk);
            start = 1'b0; advance = 1'b0; solved = 1'b0;
            got = {idx3, v3, r3, s3, g3};
            e = exp_q.pop_front();
            chk($sformatf("vec%0d", i), 32'(got), 32'(e));
        end

        // five indices used on the 16-round instance, then reset mid-SEEK
        reset_and_start16();
        @(negedge clk);
        chk("first_idx_16", 32'({idx16, v16}), 32'({4'd2, 1'b1}));
        for (int k = 0; k < 4; k++) begin
            advance16(1'b1);
            wait_valid16(cyc);
            chk($sformatf("pre_seek%0d", k), 32'(v16), 32'd1);
        end
        advance16(1'b0);
        chk("in_seek_before_rst", 32'(v16), 32'd0);
        rst = 1'b1; start = 1'b1; advance = 1'b1; solved = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0; advance = 1'b0; solved = 1'b0;
        chk("rst_mid_seek", 32'({idx16, v16, r16, s16, g16}), 32'd0);

        // fresh game: index 2 was used before reset, so it must come straight back
        repeat (2) @(negedge clk);
        start = 1'b1;
        exp16_q.push_back({5'd1, 5'd0});
        @(negedge clk);
        start = 1'b0;
        chk("fresh_seek", 32'({v16, r16, s16, g16}), 32'({1'b0, 5'd1, 5'd0, 1'b0}));
        @(negedge clk);
        chk("fresh_idx", 32'({idx16, v16}), 32'({4'd2, 1'b1}));

        seen = 16'd0;
        exp_score = 0;
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("present%0d", k), 32'(v16), 32'd1);
            chk($sformatf("round_score%0d", k), 32'({r16, s16}),
                32'(exp16_q.size() > 0 ? exp16_q.pop_front() : 10'h3ff));
            chk($sformatf("distinct%0d", k), 32'(seen[idx16]), 32'd0);
            seen[idx16] = 1'b1;
            sol = 1'($urandom_range(0, 1));
            exp_score += int'(sol);
            if (k < 16) exp16_q.push_back({5'(k + 1), 5'(exp_score)});
            advance16(sol);
            if (k < 16) begin
                wait_valid16(cyc);
                chk($sformatf("seek_bound%0d", k), 32'(cyc <= 16), 32'd1);
            end
        end
        chk("final_state", 32'({v16, r16, s16, g16}), 32'({1'b0, 5'd16, 5'(exp_score), 1'b1}));
        chk("all_indices", 32'(seen), 32'hffff);

        // advance in DONE must not disturb anything
        advance = 1'b1; solved = 1'b1;
        @(negedge clk);
        advance = 1'b0; solved = 1'b0;
        chk("done_adv_ignored", 32'({v16, r16, s16, g16}), 32'({1'b0, 5'd16, 5'(exp_score), 1'b1}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
